// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for the load/store unit.
// slave = LSU side; master = core + memory side.
interface load_store_unit_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_rd_valid_o;
  logic        core_stall_o;
  logic        misaligned_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i,
    input  core_addr_i, core_wd_i,
    output core_rd_o, core_rd_valid_o,
    output core_stall_o, misaligned_o, fault_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport master (
    output core_req_i, core_we_i, core_size_i,
    output core_addr_i, core_wd_i,
    input  core_rd_o, core_rd_valid_o,
    input  core_stall_o, misaligned_o, fault_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/BUSY/DONE FSM, lane steering,
// load extension, misalign/illegal-size checks and bus timeout.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport).
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  load_store_unit_if.slave bus
);

  localparam int CLW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW  = (CLW > 8) ? CLW : 8;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [2:0]  sz_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        rdv_q;
  logic        flt_q;

  logic        legal;
  logic        aligned;
  logic        start;
  logic        tmo;
  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic [31:0] lane;
  logic [31:0] ld_data;

  logic [2:0]  sz;
  logic [1:0]  a10;
  assign sz  = bus.core_size_i;
  assign a10 = bus.core_addr_i[1:0];

  // BU/HU exist only as loads.
  always_comb begin
    legal = 1'b0;
    unique case (sz)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~bus.core_we_i;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    unique case (sz[1:0])
      2'b01:   aligned = ~a10[0];
      2'b10:   aligned = (a10 == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    be_d = 4'b1111;
    wd_d = bus.core_wd_i;
    unique case (sz[1:0])
      2'b00: begin
        be_d = 4'b0001 << a10;
        wd_d = {4{bus.core_wd_i[7:0]}};
      end
      2'b01: begin
        be_d = a10[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{bus.core_wd_i[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = bus.core_wd_i;
      end
    endcase
  end

  assign start = (state_q == IDLE) && bus.core_req_i
               && legal && aligned;
  assign tmo   = (cnt_q == CNT_LAST);

  // Shift the addressed lane down to bit 0, then extend.
  assign lane = bus.mem_rd_i >> {off_q, 3'b000};

  always_comb begin
    ld_data = bus.mem_rd_i;
    unique case (sz_q)
      3'b000: ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b100: ld_data = {24'd0, lane[7:0]};
      3'b001: ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b101: ld_data = {16'd0, lane[15:0]};
      default: ld_data = bus.mem_rd_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (bus.mem_ready_i || tmo) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sz_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      rdv_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        we_q   <= bus.core_we_i;
        sz_q   <= sz;
        off_q  <= a10;
        addr_q <= {bus.core_addr_i[31:2], 2'b00};
        be_q   <= be_d;
        wd_q   <= wd_d;
        cnt_q  <= '0;
        rdv_q  <= 1'b0;
        flt_q  <= 1'b0;
      end else if (state_q == BUSY) begin
        // Ready beats timeout in the same cycle.
        if (bus.mem_ready_i) begin
          rdv_q <= ~we_q;
          flt_q <= 1'b0;
          if (!we_q) rd_q <= ld_data;
        end else if (tmo) begin
          rdv_q <= 1'b0;
          flt_q <= 1'b1;
          if (!we_q) rd_q <= 32'd0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  logic idle_req;
  assign idle_req = (state_q == IDLE) && bus.core_req_i;

  assign bus.core_rd_o       = rd_q;
  assign bus.core_rd_valid_o = (state_q == DONE) && rdv_q;
  assign bus.core_stall_o    = start || (state_q == BUSY);
  assign bus.misaligned_o    = idle_req && legal && !aligned;
  assign bus.fault_o         = (idle_req && !legal)
                             || ((state_q == DONE) && flt_q);
  assign bus.mem_req_o       = (state_q == BUSY);
  assign bus.mem_we_o        = (state_q == BUSY) && we_q;
  assign bus.mem_be_o        = be_q;
  assign bus.mem_addr_o      = addr_q;
  assign bus.mem_wd_o        = wd_q;

endmodule
